// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1 without wrapping; sized to WIDTH+1 values.
  function automatic int cnt_width(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_1bit.sv
// Purely combinational 1-bit full adder shared by every bit step.
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: one full adder stepped WIDTH times, LSB first.
// Optional subtract/overflow support is built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_SUB_EN
  ,
  input  logic             sub,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sh, b_sh, next_a_sh, b_load;
  logic [CW-1:0]    cnt;
  logic             carry, carry_load;
  logic             fa_s, fa_cout;
  logic             last_bit, accept;

  fa_1bit u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && ready;

  // The A shift register doubles as the partial sum: each sum bit enters at
  // the MSB as an operand bit leaves at the LSB, so it never exposes partials.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign next_a_sh = fa_s;
    end else begin : g_wide
      assign next_a_sh = {fa_s, a_sh[WIDTH-1:1]};
    end
  endgenerate

`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = last_bit ? DONE : RUN;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    begin ready = 1'b1; done = 1'b1; end
      default: ready = 1'b0;
    endcase
  end

  // Result outputs change only on the final RUN step, i.e. on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b_load;
      carry <= carry_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= next_a_sh;
      b_sh  <= b_sh >> 1;
      carry <= fa_cout;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= next_a_sh;
        cout <= fa_cout;
`ifdef SERIAL_ADD_SUB_EN
        ovf  <= carry ^ fa_cout;
`endif
      end
    end
  end

endmodule
